// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
package uart_tx_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: produces a one-cycle tick on the last clock of each
// serial bit. The count restarts from zero whenever clear is asserted so
// every state of the serializer gets a full bit period.
module baud_tick_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic o_tick
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear forces a fresh bit period.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (r_count == LAST_CNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST_CNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first,
// optional even parity bit, one stop bit. Closes the Start_Tx / Tx_Done
// handshake with the TX control FSM.
// Build option: define UART_TX_PARITY_EN to add the even-parity bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int            BW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 w_tick;
    logic                 w_state_change;
    logic                 w_serial;
    logic                 w_busy;
    logic                 w_done;
    logic                 r_tx_serial;
    logic                 r_tx_busy;
    logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    // Every state entry restarts the bit timer.
    assign w_state_change = (w_state_next != r_state);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_state_change),
        .o_tick (w_tick)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start_tx only matters in IDLE.
    // NOTE: the default assignment first keeps this purely combinational;
    // a path that leaves w_state_next unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_tx) w_state_next = ST_START;
            ST_START:  if (w_tick)   w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_tick)   w_state_next = ST_STOP;
`endif
            ST_STOP:   if (w_tick)   w_state_next = ST_DONE;
            ST_DONE:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Shift register captures on acceptance and shifts right at each data
    // bit end; the bit counter restarts as DATA is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && start_tx) begin
                r_shift <= tx_data;
            end else if (r_state == ST_DATA && w_tick) begin
                r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == ST_START && w_tick) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_DATA && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is computed once from the byte as it is captured, since
    // the shift register no longer holds it by the time PARITY is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_IDLE && start_tx) begin
            r_parity <= ^tx_data;
        end
    end
`endif

    // Output decode from the current state (line idles high).
    always_comb begin
        w_serial = 1'b1;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_START: begin
                w_serial = 1'b0;
                w_busy   = 1'b1;
            end
            ST_DATA: begin
                w_serial = r_shift[0];
                w_busy   = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_serial = r_parity;
                w_busy   = 1'b1;
            end
`endif
            ST_STOP: begin
                w_busy   = 1'b1;
            end
            ST_DONE: begin
                w_done   = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs: the line lags the state by one cycle, giving the
    // controller a glitch-free, input-isolated view.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_serial <= w_serial;
            r_tx_busy   <= w_busy;
            r_tx_done   <= w_done;
        end
    end

    assign tx_serial = r_tx_serial;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4, DATA_BITS=8).
// Expected frames are queued by the driver and checked by a line monitor.
module tb_uart_tx_serializer;

    localparam int C  = 4;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 2 + DB + PAR;   // bits per frame
    localparam int F  = NB * C;         // frame length in cycles
    localparam int P  = F + 2;          // back-to-back acceptance period

    typedef struct {
        logic [DB-1:0] data;
        int            acc;    // edge number that accepts start_tx
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_tx;
    logic [DB-1:0] tx_data;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    exp_t exp_q[$];

    uart_tx_serializer #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_tx (start_tx),
        .tx_data  (tx_data),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic send(input logic [DB-1:0] d, output int acc);
        exp_t e;
        @(posedge clk); #1;
        start_tx = 1'b1;
        tx_data  = d;
        acc      = cyc + 1;
        e.data   = d;
        e.acc    = acc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_tx = 1'b0;
    endtask

    task automatic check_latency(input string tag, input int acc);
        if (done_cyc.size() > 0) check(tag, done_cyc[$] - acc, F + 1);
        else                     check(tag, 0, F + 1);
    endtask

    // Follows one frame from its first start-bit sample; a reset inside the
    // frame discards the queued expectation.
    task automatic capture_frame(input int e_start);
        logic [NB-1:0] fr;
        int            glitches;
        int            not_busy;
        exp_t          e;
        fr       = '0;
        glitches = 0;
        not_busy = 0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < C; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (reset === 1'b1) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    return;
                end
                if (c == 0) fr[b] = tx_serial;
                else if (tx_serial !== fr[b]) glitches++;
                if (tx_busy !== 1'b1) not_busy++;
            end
        end
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("start_edge", e_start, e.acc + 1);
        check("start_bit", fr[0], 0);
        check("data", fr[DB:1], e.data);
`ifdef UART_TX_PARITY_EN
        check("parity", fr[DB+1], ^e.data);
`endif
        check("stop_bit", fr[NB-1], 1);
        check("bit_stable", glitches, 0);
        check("busy_in_frame", not_busy, 0);
        @(negedge clk);
        check("done_pulse", tx_done, 1);
        check("done_busy_low", tx_busy, 0);
        check("done_edge", cyc, e.acc + 1 + F);
        @(negedge clk);
        check("done_one_cycle", tx_done, 0);
        check("idle_gap_high", tx_serial, 1);
    endtask

    // Line monitor: a high-to-low transition outside reset is a start bit.
    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && prev === 1'b1 && tx_serial === 1'b0)
                capture_frame(cyc);
            prev = tx_serial;
        end
    end

    initial begin : stimulus
        int acc;
        int d0;
        int a0;
        int n;
        int lows;
        int busys;
        exp_t e;

        reset    = 1'b1;
        start_tx = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", tx_serial, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        reset = 1'b0;

        // Single frames: 0xA5, then parity-sensitive 0x07 / 0x03
        d0 = done_cnt;
        send(8'hA5, acc);
        repeat (F + 8) @(posedge clk);
        check("a5_done_count", done_cnt - d0, 1);
        check_latency("a5_latency", acc);

        d0 = done_cnt;
        send(8'h07, acc);
        repeat (F + 8) @(posedge clk);
        check("07_done_count", done_cnt - d0, 1);
        check_latency("07_latency", acc);

        d0 = done_cnt;
        send(8'h03, acc);
        repeat (F + 8) @(posedge clk);
        check("03_done_count", done_cnt - d0, 1);

        // start_tx and tx_data disturbed mid-frame
        d0 = done_cnt;
        send(8'h3C, acc);
        repeat (10) @(posedge clk);
        #1;
        start_tx = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk); #1;
        start_tx = 1'b0;
        repeat (F + 8) @(posedge clk);
        check("midstart_done_count", done_cnt - d0, 1);

        // start_tx held high: three back-to-back frames
        d0 = done_cnt;
        @(posedge clk); #1;
        start_tx = 1'b1;
        tx_data  = 8'h55;
        a0       = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.data = 8'h55;
            e.acc  = a0 + i * P;
            exp_q.push_back(e);
        end
        repeat (2 * P + 1) @(posedge clk);
        #1;
        start_tx = 1'b0;
        repeat (F + 8) @(posedge clk);
        check("b2b_done_count", done_cnt - d0, 3);
        n = done_cyc.size();
        if (n >= 3) begin
            check("b2b_gap_1", done_cyc[n-2] - done_cyc[n-3], P);
            check("b2b_gap_2", done_cyc[n-1] - done_cyc[n-2], P);
        end else begin
            check("b2b_gaps_seen", n, 3);
        end

        // Reset during the 5th data bit aborts the frame
        d0 = done_cnt;
        send(8'hC3, acc);
        repeat (5 * C + 1) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_serial", tx_serial, 1);
        check("abort_busy", tx_busy, 0);
        repeat (F) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        send(8'h81, acc);
        repeat (F + 8) @(posedge clk);
        check("post_abort_done_count", done_cnt - d0, 1);
        check_latency("post_abort_latency", acc);

        // reset and start_tx together: reset wins
        d0 = done_cnt;
        @(posedge clk); #1;
        reset    = 1'b1;
        start_tx = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk); #1;
        reset    = 1'b0;
        start_tx = 1'b0;
        lows  = 0;
        busys = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        check("rst_start_line_high", lows, 0);
        check("rst_start_not_busy", busys, 0);
        check("rst_start_no_done", done_cnt - d0, 0);

        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
